// File: rtl/vpu_src_burst_controller_pkg.sv
// Shared definitions for the VPU source burst controller: default SRAM
// geometry, the burst FSM state type and operand-address split helpers.
package vpu_src_burst_controller_pkg;

    localparam int SRAM_BANK_CNT_LG2   = 3;
    localparam int SRAM_BANK_DEPTH_LG2 = 10;
    localparam int SRAM_DATA_WIDTH     = 256;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } src_burst_state_t;

    // Bank index: everything above the row field.
    function automatic logic [31:0] get_bank_id(input logic [31:0] addr, input int depth_lg2);
        return addr >> depth_lg2;
    endfunction

    // Row index within the bank: the low depth_lg2 bits.
    function automatic logic [31:0] get_raddr(input logic [31:0] addr, input int depth_lg2);
        return addr & ((32'd1 << depth_lg2) - 32'd1);
    endfunction

endpackage

// File: rtl/vpu_src_burst_controller_if.sv
// Handshake bundle of one VPU source port: burst command, operand queue
// push/pop and the SRAM read port. The slave modport is the engine's view.
interface vpu_src_burst_controller_if #(
    parameter int ADDR_W    = 16,
    parameter int BANK_LG2  = 3,
    parameter int DEPTH_LG2 = 10,
    parameter int DATA_W    = 256,
    parameter int LEN_W     = 4
);
    logic                 valid_i;
    logic [ADDR_W-1:0]    raddr_i;
    logic [LEN_W-1:0]     rlen_i;
    logic                 ready_o;

    logic                 fifo_pop_i;
    logic [DATA_W-1:0]    fifo_wdata_o;
    logic                 fifo_wren_o;

    logic                 sram_req_o;
    logic [BANK_LG2-1:0]  sram_rid_o;
    logic [DEPTH_LG2-1:0] sram_addr_o;
    logic                 sram_reb_o;
    logic                 sram_rlast_o;
    logic                 sram_ack_i;
    logic                 sram_rvalid_i;
    logic [DATA_W-1:0]    sram_rdata_i;

    modport slave (
        input  valid_i, raddr_i, rlen_i, fifo_pop_i,
        input  sram_ack_i, sram_rvalid_i, sram_rdata_i,
        output ready_o, fifo_wdata_o, fifo_wren_o,
        output sram_req_o, sram_rid_o, sram_addr_o, sram_reb_o, sram_rlast_o
    );

    modport master (
        output valid_i, raddr_i, rlen_i, fifo_pop_i,
        output sram_ack_i, sram_rvalid_i, sram_rdata_i,
        input  ready_o, fifo_wdata_o, fifo_wren_o,
        input  sram_req_o, sram_rid_o, sram_addr_o, sram_reb_o, sram_rlast_o
    );

endinterface

// File: rtl/vpu_src_burst_controller_credit_counter.sv
// Bounded up/down counter. An increment at MAX or a decrement at zero is
// dropped and reported on err for that cycle; the other event still applies.
module vpu_credit_counter #(
    parameter int W    = 3,
    parameter int MAX  = 4,
    parameter int INIT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt,
    output logic         err
);
    localparam logic [W-1:0] MAX_V  = W'(MAX);
    localparam logic [W-1:0] INIT_V = W'(INIT);

    logic at_max;
    logic at_zero;
    logic inc_ok;
    logic dec_ok;

    // Filter illegal events and form the next count.
    always_comb begin
        at_max    = (count == MAX_V);
        at_zero   = (count == '0);
        inc_ok    = inc & ~at_max;
        dec_ok    = dec & ~at_zero;
        err       = (inc & at_max) | (dec & at_zero);
        count_nxt = count;
        if (inc_ok & ~dec_ok) begin
            count_nxt = count + 1'b1;
        end else if (dec_ok & ~inc_ok) begin
            count_nxt = count - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= INIT_V;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/vpu_src_burst_controller.sv
// Operand-fetch engine for one VPU source port: turns a burst command into
// consecutive SRAM row reads, forwarding returned rows to the operand queue
// under credit-based flow control.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a command; done when nothing is outstanding
// S_ISSUE | issuing row reads, paused while no queue credit is left
// S_DRAIN | all beats issued, waiting for the remaining read returns
module vpu_src_burst_controller
    import vpu_src_burst_controller_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int BANK_LG2  = SRAM_BANK_CNT_LG2,
    parameter int DEPTH_LG2 = SRAM_BANK_DEPTH_LG2,
    parameter int DATA_W    = SRAM_DATA_WIDTH,
    parameter int LEN_W     = 4,
    parameter int CREDITS   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic done_o,
    output logic err_o,
    vpu_src_burst_controller_if.slave bus
);
    localparam int CNT_W = $clog2(CREDITS + 1);

    src_burst_state_t     state_q;
    src_burst_state_t     state_d;
    logic [BANK_LG2-1:0]  bank_q;
    logic [DEPTH_LG2-1:0] row_q;
    logic [LEN_W-1:0]     beats_q;
    logic                 req_q;
    logic                 req_d;
    logic                 req_live;
    logic                 accept;
    logic                 ready;
    logic                 done;
    logic                 beat;
    logic                 last_beat;
    logic                 err_q;

    logic [ADDR_W-1:0]    cmd_addr;
    logic [BANK_LG2-1:0]  cmd_bank;
    logic [DEPTH_LG2-1:0] cmd_row;
    logic [DATA_W-1:0]    rdata;

    logic [CNT_W-1:0]     credits;
    logic [CNT_W-1:0]     credits_nxt;
    logic                 credits_err;
    logic [CNT_W-1:0]     outstanding;
    logic [CNT_W-1:0]     outstanding_nxt;
    logic                 outstanding_err;

    assign cmd_addr = bus.raddr_i;
    assign cmd_bank = BANK_LG2'(get_bank_id(32'(cmd_addr), DEPTH_LG2));
    assign cmd_row  = DEPTH_LG2'(get_raddr(32'(cmd_addr), DEPTH_LG2));

    // req_q already implies a credit was available; the extra term keeps a
    // request from ever going out against an empty credit pool.
    assign req_live  = req_q & (credits != '0);
    assign beat      = req_live & bus.sram_ack_i;
    assign last_beat = beat & (beats_q == '0);

    assign bus.sram_req_o   = req_live;
    assign bus.sram_rid_o   = req_live ? bank_q : '0;
    assign bus.sram_addr_o  = req_live ? row_q : '0;
    assign bus.sram_reb_o   = ~req_live;
    assign bus.sram_rlast_o = req_live & (beats_q == '0);

    assign rdata            = bus.sram_rdata_i;
    assign bus.fifo_wdata_o = rdata;
    assign bus.fifo_wren_o  = bus.sram_rvalid_i;

    assign bus.ready_o = ready;
    assign done_o      = done;
    assign err_o       = err_q;

    vpu_credit_counter #(
        .W    (CNT_W),
        .MAX  (CREDITS),
        .INIT (CREDITS)
    ) u_credits (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (bus.fifo_pop_i),
        .dec       (beat),
        .count     (credits),
        .count_nxt (credits_nxt),
        .err       (credits_err)
    );

    vpu_credit_counter #(
        .W    (CNT_W),
        .MAX  (CREDITS),
        .INIT (0)
    ) u_outstanding (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (beat),
        .dec       (bus.sram_rvalid_i),
        .count     (outstanding),
        .count_nxt (outstanding_nxt),
        .err       (outstanding_err)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, command handshake and next-cycle request.
    always_comb begin
        state_d = state_q;
        req_d   = 1'b0;
        ready   = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                done  = (outstanding == '0);
                ready = start_i & (outstanding == '0);
                if (bus.valid_i & ready) begin
                    accept  = 1'b1;
                    state_d = S_ISSUE;
                    req_d   = (credits_nxt != '0);
                end
            end
            S_ISSUE: begin
                if (last_beat) begin
                    state_d = S_DRAIN;
                end else begin
                    req_d = (credits_nxt != '0);
                end
            end
            S_DRAIN: begin
                if (outstanding_nxt == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Burst address and beat bookkeeping; the row wraps inside its bank.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            bank_q  <= '0;
            row_q   <= '0;
            beats_q <= '0;
        end else begin
            req_q <= req_d;
            if (accept) begin
                bank_q  <= cmd_bank;
                row_q   <= cmd_row;
                beats_q <= bus.rlen_i;
            end else if (beat) begin
                row_q   <= row_q + 1'b1;
                beats_q <= beats_q - 1'b1;
            end
        end
    end

    // Sticky protocol error: stray read return or pop with no entry issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (credits_err | outstanding_err) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vpu_src_burst_controller.sv
// Directed bench for vpu_src_burst_controller. Inputs change on the falling
// edge; outputs are observed 1 ns after it, well away from the rising edge.
module tb_vpu_src_burst_controller;

    localparam int ADDR_W    = 16;
    localparam int BANK_LG2  = 3;
    localparam int DEPTH_LG2 = 10;
    localparam int DATA_W    = 256;
    localparam int LEN_W     = 4;
    localparam int CREDITS   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic done;
    logic err;

    int total = 0;
    int bad   = 0;

    int nb;
    int nw;
    int fifo_level;
    logic [2:0]   b_rid [32];
    logic [9:0]   b_addr[32];
    logic         b_last[32];
    int           b_cyc [32];
    logic [255:0] w_data[32];

    vpu_src_burst_controller_if #(
        .ADDR_W(ADDR_W), .BANK_LG2(BANK_LG2), .DEPTH_LG2(DEPTH_LG2),
        .DATA_W(DATA_W), .LEN_W(LEN_W)
    ) bus ();

    vpu_src_burst_controller #(
        .ADDR_W(ADDR_W), .BANK_LG2(BANK_LG2), .DEPTH_LG2(DEPTH_LG2),
        .DATA_W(DATA_W), .LEN_W(LEN_W), .CREDITS(CREDITS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .done_o  (done),
        .err_o   (err),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] pat(input logic [2:0] r, input logic [9:0] a);
        return {16{3'b000, r, a}};
    endfunction

    task automatic clear_rec();
        nb = 0;
        nw = 0;
    endtask

    // Present a command and hold it until accepted (bounded). Returns at the
    // falling edge right after the accepting rising edge.
    task automatic drive_cmd(input logic [15:0] a, input logic [3:0] l, output bit ok);
        int w;
        w = 0;
        start = 1'b1;
        bus.valid_i = 1'b1;
        bus.raddr_i = a;
        bus.rlen_i  = l;
        #1;
        while (!bus.ready_o && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        ok = bus.ready_o;
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    // SRAM return model and beat/push recorder: each beat is answered
    // lat cycles later, queue entries are popped one per cycle if enabled.
    task automatic collect(input int nbeats, input int lat, input bit auto_pop, input int budget);
        int ret_q[$];
        int c;
        int nb0;
        int nw0;
        int rk;
        nb0 = nb;
        nw0 = nw;
        rk  = nw;
        c   = 0;
        while (((nb - nb0) < nbeats || (nw - nw0) < nbeats) && c < budget) begin
            if (ret_q.size() > 0 && ret_q[0] <= c) begin
                void'(ret_q.pop_front());
                bus.sram_rvalid_i = 1'b1;
                bus.sram_rdata_i  = (rk < 32) ? pat(b_rid[rk], b_addr[rk]) : '0;
                rk++;
            end else begin
                bus.sram_rvalid_i = 1'b0;
            end
            bus.fifo_pop_i = auto_pop && fifo_level > 0;
            if (bus.fifo_pop_i) fifo_level--;
            #1;
            if (bus.sram_req_o && bus.sram_ack_i) begin
                if (nb < 32) begin
                    b_rid[nb]  = bus.sram_rid_o;
                    b_addr[nb] = bus.sram_addr_o;
                    b_last[nb] = bus.sram_rlast_o;
                    b_cyc[nb]  = c;
                end
                nb++;
                ret_q.push_back(c + lat);
            end
            if (bus.fifo_wren_o) begin
                if (nw < 32) w_data[nw] = bus.fifo_wdata_o;
                nw++;
                fifo_level++;
            end
            c++;
            @(negedge clk);
        end
        bus.sram_rvalid_i = 1'b0;
        bus.fifo_pop_i    = 1'b0;
    endtask

    task automatic flush_fifo();
        int g;
        g = 0;
        while (fifo_level > 0 && g < 40) begin
            bus.fifo_pop_i = 1'b1;
            fifo_level--;
            g++;
            @(negedge clk);
        end
        bus.fifo_pop_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] rq;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rq = {bus.sram_req_o, bus.sram_rid_o, bus.sram_addr_o, bus.sram_reb_o, bus.sram_rlast_o};
        total++;
        if (rq !== {1'b0, 3'd0, 10'd0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL reset_sram got=%h exp=%h", rq, {1'b0, 3'd0, 10'd0, 1'b1, 1'b0});
        end
        total++;
        if ({bus.fifo_wren_o, err, bus.ready_o, done} !== 4'b0001) begin
            bad++; $display("FAIL reset_ctl {wren,err,ready,done} got=%b exp=0001",
                            {bus.fifo_wren_o, err, bus.ready_o, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_beat();
        bit ok;
        logic [15:0] rq;
        clear_rec();
        bus.sram_ack_i = 1'b1;
        drive_cmd(16'h1403, 4'd0, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL single_accept got=%0d exp=1", ok); end
        #1;
        rq = {bus.sram_req_o, bus.sram_rid_o, bus.sram_addr_o, bus.sram_reb_o, bus.sram_rlast_o};
        total++;
        if (rq !== {1'b1, 3'd5, 10'h003, 1'b0, 1'b1}) begin
            bad++; $display("FAIL single_req got=%h exp=%h", rq, {1'b1, 3'd5, 10'h003, 1'b0, 1'b1});
        end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", done); end
        collect(1, 3, 1'b0, 20);
        total++;
        if (nb !== 1 || nw !== 1) begin
            bad++; $display("FAIL single_counts beats=%0d pushes=%0d exp=1/1", nb, nw);
        end
        total++;
        if (w_data[0] !== pat(3'd5, 10'h003)) begin
            bad++; $display("FAIL single_data got=%h exp=%h", w_data[0], pat(3'd5, 10'h003));
        end
        @(negedge clk);
        #1;
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL single_done got=%b exp=1", done); end
        flush_fifo();
    endtask

    task automatic test_burst();
        bit ok;
        clear_rec();
        bus.sram_ack_i = 1'b1;
        drive_cmd(16'h0C20, 4'd7, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL burst_accept got=%0d exp=1", ok); end
        collect(4, 2, 1'b0, 20);
        total++;
        if (nb !== 4) begin bad++; $display("FAIL burst_first_beats got=%0d exp=4", nb); end
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (bus.sram_req_o !== 1'b0) begin
                bad++; $display("FAIL burst_stall_req cyc=%0d got=%b exp=0", i, bus.sram_req_o);
            end
            @(negedge clk);
        end
        collect(4, 2, 1'b1, 40);
        total++;
        if (nb !== 8 || nw !== 8) begin
            bad++; $display("FAIL burst_counts beats=%0d pushes=%0d exp=8/8", nb, nw);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({b_rid[i], b_addr[i], b_last[i]} !== {3'd3, 10'(10'h020 + i), (i == 7)}) begin
                bad++; $display("FAIL burst_beat%0d got=%h exp=%h", i,
                                {b_rid[i], b_addr[i], b_last[i]}, {3'd3, 10'(10'h020 + i), (i == 7)});
            end
            total++;
            if (w_data[i] !== pat(3'd3, 10'(10'h020 + i))) begin
                bad++; $display("FAIL burst_data%0d got=%h exp=%h", i, w_data[i], pat(3'd3, 10'(10'h020 + i)));
            end
        end
        flush_fifo();
        #1;
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL burst_done got=%b exp=1", done); end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [9:0] exp_a[4];
        exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
        clear_rec();
        bus.sram_ack_i = 1'b1;
        drive_cmd(16'h0BFE, 4'd3, ok);
        collect(4, 1, 1'b1, 30);
        total++;
        if (nb !== 4) begin bad++; $display("FAIL wrap_beats got=%0d exp=4", nb); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({b_rid[i], b_addr[i]} !== {3'd2, exp_a[i]}) begin
                bad++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, {b_rid[i], b_addr[i]}, {3'd2, exp_a[i]});
            end
        end
        flush_fifo();
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [15:0] rq;
        clear_rec();
        bus.sram_ack_i = 1'b0;
        drive_cmd(16'h1C10, 4'd1, ok);
        for (int i = 0; i < 5; i++) begin
            #1;
            rq = {bus.sram_req_o, bus.sram_rid_o, bus.sram_addr_o, bus.sram_reb_o, bus.sram_rlast_o};
            total++;
            if (rq !== {1'b1, 3'd7, 10'h010, 1'b0, 1'b0}) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i, rq, {1'b1, 3'd7, 10'h010, 1'b0, 1'b0});
            end
            @(negedge clk);
        end
        bus.sram_ack_i = 1'b1;
        collect(2, 2, 1'b1, 30);
        total++;
        if (nb !== 2) begin bad++; $display("FAIL bp_beats got=%0d exp=2", nb); end
        total++;
        if ({b_addr[0], b_last[0], b_addr[1], b_last[1]} !== {10'h010, 1'b0, 10'h011, 1'b1}) begin
            bad++; $display("FAIL bp_addr got=%h exp=%h",
                            {b_addr[0], b_last[0], b_addr[1], b_last[1]}, {10'h010, 1'b0, 10'h011, 1'b1});
        end
        flush_fifo();
    endtask

    task automatic test_simultaneous();
        bit ok;
        clear_rec();
        bus.sram_ack_i = 1'b1;
        drive_cmd(16'h0400, 4'd7, ok);
        collect(8, 1, 1'b1, 40);
        total++;
        if (nb !== 8 || nw !== 8) begin
            bad++; $display("FAIL simul_counts beats=%0d pushes=%0d exp=8/8", nb, nw);
        end
        total++;
        if (b_cyc[7] - b_cyc[0] !== 7) begin
            bad++; $display("FAIL simul_span got=%0d exp=7", b_cyc[7] - b_cyc[0]);
        end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL simul_err got=%b exp=0", err); end
        flush_fifo();
        #1;
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL simul_done got=%b exp=1", done); end
    endtask

    task automatic test_errors();
        @(negedge clk);
        bus.sram_rvalid_i = 1'b1;
        bus.sram_rdata_i  = pat(3'd6, 10'h155);
        #1;
        total++;
        if ({bus.fifo_wren_o, bus.fifo_wdata_o} !== {1'b1, pat(3'd6, 10'h155)}) begin
            bad++; $display("FAIL err_passthru wren=%b data=%h exp=1/%h",
                            bus.fifo_wren_o, bus.fifo_wdata_o, pat(3'd6, 10'h155));
        end
        @(negedge clk);
        bus.sram_rvalid_i = 1'b0;
        #1;
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_stray_rvalid got=%b exp=1", err); end
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL err_reset_clear got=%b exp=0", err); end
        @(negedge clk);
        bus.fifo_pop_i = 1'b1;
        @(negedge clk);
        bus.fifo_pop_i = 1'b0;
        #1;
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_pop_full got=%b exp=1", err); end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        logic [15:0] rq;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fifo_level = 0;
        clear_rec();
        bus.sram_ack_i = 1'b0;
        drive_cmd(16'h1403, 4'd7, ok);
        #1;
        total++;
        if (bus.sram_req_o !== 1'b1) begin bad++; $display("FAIL rstmid_req got=%b exp=1", bus.sram_req_o); end
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        #1;
        rq = {bus.sram_req_o, bus.sram_rid_o, bus.sram_addr_o, bus.sram_reb_o, bus.sram_rlast_o};
        total++;
        if (rq !== {1'b0, 3'd0, 10'd0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL rstmid_sram got=%h exp=%h", rq, {1'b0, 3'd0, 10'd0, 1'b1, 1'b0});
        end
        total++;
        if ({bus.fifo_wren_o, err, bus.ready_o, done} !== 4'b0001) begin
            bad++; $display("FAIL rstmid_ctl {wren,err,ready,done} got=%b exp=0001",
                            {bus.fifo_wren_o, err, bus.ready_o, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.sram_rvalid_i = 1'b1;
        @(negedge clk);
        bus.sram_rvalid_i = 1'b0;
        #1;
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL rstmid_late_rvalid got=%b exp=1", err); end
    endtask

    initial begin
        bus.valid_i       = 1'b0;
        bus.raddr_i       = '0;
        bus.rlen_i        = '0;
        bus.fifo_pop_i    = 1'b0;
        bus.sram_ack_i    = 1'b0;
        bus.sram_rvalid_i = 1'b0;
        bus.sram_rdata_i  = '0;
        fifo_level        = 0;
        nb                = 0;
        nw                = 0;
        test_reset();
        test_single_beat();
        test_burst();
        test_wrap();
        test_backpressure();
        test_simultaneous();
        test_errors();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
